// File: rtl/wb_arb_pkg.sv
// Shared encodings and helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TURN  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam int MAX_MASTERS = 4;
  localparam int GRANT_WIDTH = 2;

  function automatic logic [GRANT_WIDTH-1:0] rr_index(
    input logic [GRANT_WIDTH-1:0] base,
    input int                     step,
    input int                     n
  );
    int v;
    v = (int'(base) + step) % n;
    return GRANT_WIDTH'(v);
  endfunction

endpackage

// File: rtl/wishbone_rr_arbiter_picker.sv
// Combinational round-robin picker: first eligible index after the
// last owner, wrapping at MASTERS.
module rr_priority_picker
  import wb_arb_pkg::*;
#(
  parameter int MASTERS = 4
) (
  input  logic [MASTERS-1:0]     i_eligible,
  input  logic [GRANT_WIDTH-1:0] i_last,
  output logic                   o_found,
  output logic [GRANT_WIDTH-1:0] o_index
);

  logic [GRANT_WIDTH-1:0] w_cand;

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_cand  = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      w_cand = rr_index(i_last, k, MASTERS);
      if (!o_found && i_eligible[w_cand]) begin
        o_found = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin owner control for a shared Wishbone slave, with bus
// turnaround and a stalled-transfer watchdog with per-master lockout.
module wishbone_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MASTERS        = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [MASTERS-1:0]     request,
  input  logic                   slave_stb,
  input  logic                   slave_ack,
  input  logic                   slave_error,
  output logic                   grant_valid,
  output logic [GRANT_WIDTH-1:0] grant_index,
  output logic                   timeout_error,
  output logic [MASTERS-1:0]     locked_out,
  output logic [1:0]             probe_state
);

  localparam logic [TIMEOUT_WIDTH-1:0] LP_LIMIT =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_SAT = '1;
  localparam logic [GRANT_WIDTH-1:0] LP_LAST_RST =
    GRANT_WIDTH'(MASTERS - 1);
  localparam logic LP_WD_EN = (TIMEOUT_CYCLES != 0);

  state_t                   r_state;
  state_t                   w_state_nx;
  logic [GRANT_WIDTH-1:0]   r_gidx;
  logic [GRANT_WIDTH-1:0]   w_gidx_nx;
  logic [GRANT_WIDTH-1:0]   r_last;
  logic [GRANT_WIDTH-1:0]   w_last_nx;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic [TIMEOUT_WIDTH-1:0] w_cnt_nx;
  logic                     r_terr;
  logic                     w_terr_nx;
  logic [MASTERS-1:0]       r_lock;
  logic [MASTERS-1:0]       w_lock_nx;

  logic [MASTERS-1:0]       w_elig;
  logic                     w_found;
  logic [GRANT_WIDTH-1:0]   w_pick;
  logic                     w_owner_req;
  logic                     w_stall;
  logic                     w_abort;

  assign w_elig      = request & ~r_lock;
  assign w_owner_req = request[r_gidx];
  assign w_stall     = slave_stb & ~slave_ack & ~slave_error;

  // ack/error in the limit cycle means the transfer finished: no abort
  assign w_abort = LP_WD_EN && (r_cnt >= LP_LIMIT) &&
                   !slave_ack && !slave_error && w_owner_req;

  rr_priority_picker #(
    .MASTERS (MASTERS)
  ) u_picker (
    .i_eligible (w_elig),
    .i_last     (r_last),
    .o_found    (w_found),
    .o_index    (w_pick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state <= ST_IDLE;
      r_gidx  <= '0;
      r_last  <= LP_LAST_RST;
      r_cnt   <= '0;
      r_terr  <= 1'b0;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gidx  <= w_gidx_nx;
      r_last  <= w_last_nx;
      r_cnt   <= w_cnt_nx;
      r_terr  <= w_terr_nx;
      r_lock  <= w_lock_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gidx_nx  = r_gidx;
    w_last_nx  = r_last;
    w_cnt_nx   = '0;
    w_terr_nx  = 1'b0;
    w_lock_nx  = r_lock & request;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gidx_nx  = w_pick;
          w_last_nx  = w_pick;
          w_state_nx = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (w_stall) begin
          w_cnt_nx = (r_cnt == LP_SAT) ? r_cnt : r_cnt + 1'b1;
        end
        if (!w_owner_req) begin
          w_state_nx = ST_TURN;
        end else if (w_abort) begin
          w_terr_nx         = 1'b1;
          w_lock_nx[r_gidx] = 1'b1;
          w_state_nx        = ST_TURN;
        end
      end
      ST_TURN: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign grant_valid   = (r_state == ST_OWNED);
  assign grant_index   = r_gidx;
  assign timeout_error = r_terr;
  assign locked_out    = r_lock;
  assign probe_state   = r_state;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench for wishbone_rr_arbiter: stimulus queues expected
// grant/abort events, a negedge monitor pops and compares them.
module tb_wishbone_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] request;
  logic       stb;
  logic       ack;
  logic       err;
  logic       grant_valid;
  logic [1:0] grant_index;
  logic       timeout_error;
  logic [3:0] locked_out;
  logic [1:0] probe_state;

  int errors;
  int checks;

  typedef struct {
    int kind;
    int val;
    int gap;
  } ev_t;

  ev_t sb[$];

  wishbone_rr_arbiter #(
    .MASTERS        (4),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_WIDTH  (8)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst_n),
    .request       (request),
    .slave_stb     (stb),
    .slave_ack     (ack),
    .slave_error   (err),
    .grant_valid   (grant_valid),
    .grant_index   (grant_index),
    .timeout_error (timeout_error),
    .locked_out    (locked_out),
    .probe_state   (probe_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int val, input int gap);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic wait_grant();
    for (int c = 0; c < 20; c++) begin
      if (grant_valid) break;
      step(1);
    end
    chk("grant_wait", grant_valid, 1);
  endtask

  // Monitor
  logic prev_gv;
  int   gap_cnt;
  initial begin
    prev_gv = 1'b0;
    gap_cnt = 0;
  end

  always @(negedge clk) begin
    ev_t e;
    if (grant_valid && !prev_gv) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_grant", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_kind_grant", e.kind, 0);
        chk("sb_grant_idx", grant_index, e.val);
        if (e.gap >= 0) chk("sb_gap", gap_cnt, e.gap);
      end
    end
    if (timeout_error) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_timeout", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_kind_timeout", e.kind, 1);
        chk("sb_lock_mask", locked_out, e.val);
      end
    end
    if (grant_valid) gap_cnt = 0;
    else gap_cnt++;
    prev_gv = grant_valid;
  end

  int         order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] m;

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    request = 4'b0000;
    stb     = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    step(2);
    chk("rst_gv", grant_valid, 0);
    chk("rst_idx", grant_index, 0);
    chk("rst_terr", timeout_error, 0);
    chk("rst_lock", locked_out, 0);
    chk("rst_state", probe_state, 0);
    rst_n = 1'b1;
    step(1);

    // Single request, release
    push(0, 0, -1);
    request = 4'b0001;
    step(1);
    chk("t1_gv", grant_valid, 1);
    chk("t1_state", probe_state, 1);
    step(2);
    request = 4'b0000;
    step(1);
    chk("t1_turn_state", probe_state, 2);
    chk("t1_turn_gv", grant_valid, 0);
    step(1);
    chk("t1_idle_state", probe_state, 0);
    chk("t1_idle_gv", grant_valid, 0);

    // Round-robin from reset
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) push(0, order[i], (i == 0) ? -1 : 2);
    request = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant();
      chk("rr_idx", grant_index, order[i]);
      step(2);
      m = 4'b0001 << order[i];
      request = 4'b1111 & ~m;
      step(1);
      request = (i == 4) ? 4'b0000 : 4'b1111;
    end
    step(3);

    // Sparse wrap: last=3, then 0110
    push(0, 3, -1);
    request = 4'b1000;
    wait_grant();
    step(2);
    push(0, 1, 2);
    push(0, 2, 2);
    request = 4'b0110;
    step(1);
    wait_grant();
    chk("wrap_first", grant_index, 1);
    step(2);
    request = 4'b0100;
    step(1);
    wait_grant();
    chk("wrap_second", grant_index, 2);
    step(2);
    request = 4'b0000;
    step(3);

    // Watchdog abort on owner 2
    push(0, 2, -1);
    request = 4'b0100;
    wait_grant();
    push(1, 4'b0100, -1);
    stb = 1'b1;
    step(4);
    chk("to_pre_terr", timeout_error, 0);
    chk("to_pre_gv", grant_valid, 1);
    step(1);
    chk("to_terr", timeout_error, 1);
    chk("to_lock", locked_out, 4'b0100);
    chk("to_gv", grant_valid, 0);
    chk("to_state", probe_state, 2);
    stb = 1'b0;
    step(1);
    chk("to_pulse_end", timeout_error, 0);
    step(3);
    chk("lock_ignored_gv", grant_valid, 0);
    chk("lock_held", locked_out, 4'b0100);
    request = 4'b0000;
    step(1);
    chk("lock_cleared", locked_out, 0);
    push(0, 2, -1);
    request = 4'b0100;
    wait_grant();

    // Ack on the limit cycle: no abort
    stb = 1'b1;
    step(4);
    ack = 1'b1;
    step(1);
    chk("ack_limit_terr", timeout_error, 0);
    chk("ack_limit_gv", grant_valid, 1);
    ack = 1'b0;
    stb = 1'b0;
    step(1);

    // Owner drops cyc on the limit cycle: plain release
    stb = 1'b1;
    step(4);
    request = 4'b0000;
    step(1);
    chk("drop_limit_terr", timeout_error, 0);
    chk("drop_limit_state", probe_state, 2);
    stb = 1'b0;
    step(1);
    chk("drop_limit_lock", locked_out, 0);
    chk("drop_limit_terr2", timeout_error, 0);
    step(2);

    // Reset mid-tenure with stall count 3
    push(0, 1, -1);
    request = 4'b0010;
    wait_grant();
    stb = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("mrst_gv", grant_valid, 0);
    chk("mrst_idx", grant_index, 0);
    chk("mrst_terr", timeout_error, 0);
    chk("mrst_lock", locked_out, 0);
    chk("mrst_state", probe_state, 0);
    push(0, 0, -1);
    rst_n   = 1'b1;
    stb     = 1'b0;
    request = 4'b0011;
    wait_grant();
    chk("mrst_first", grant_index, 0);
    request = 4'b0000;
    step(3);

    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
